// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: occupancy encoding, default widths and the
// per-stage control/data field widths used when instantiating pipe_stage_reg.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   localparam int unsigned DEF_CTRL_W = 16;
   localparam int unsigned DEF_DATA_W = 160;
   localparam int unsigned DEF_CNT_W  = 16;

   // Decode->execute: two operands, PC, immediate, register indices.
   localparam int unsigned DE_CTRL_W = 16;
   localparam int unsigned DE_DATA_W = 160;
   // Execute->memory: result, store data, PC, destination index.
   localparam int unsigned EM_CTRL_W = 12;
   localparam int unsigned EM_DATA_W = 101;
   // Memory->writeback: result and destination index.
   localparam int unsigned MW_CTRL_W = 6;
   localparam int unsigned MW_DATA_W = 37;

   function automatic logic [1:0] occ_count(input occ_state_e s);
      return s;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// pipe_entry: one ctrl+data register with a valid bit. Load wins over clear;
// clear drops only the valid bit so the payload can be held for observation.
module pipe_entry
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned W = DEF_CTRL_W + DEF_DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional 2-entry skid
// buffer, flush/hold controls, bubble masking and a saturating stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned CTRL_W     = DEF_CTRL_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned SKID       = 1,
   parameter int unsigned CLEAR_DATA = 1,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              flush,
   input  logic              hold,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned W = CTRL_W + DATA_W;

   occ_state_e    state_q, state_nx;
   logic          accept, consume;
   logic          main_ld, main_clr, main_from_skid, main_valid;
   logic          skid_ld, skid_clr, skid_valid;
   logic [W-1:0]  main_d, main_q, skid_q;

   // in_ready depends only on registered state, hold and reset (never out_ready) with a skid slot.
   if (SKID != 0) begin : g_rdy_skid
      assign in_ready = rst_n && (state_q != OCC_TWO) && !hold;
   end else begin : g_rdy_pass
      assign in_ready = rst_n && ((state_q == OCC_EMPTY) || out_ready) && !hold;
   end

   assign accept  = in_valid && in_ready && !hold && !flush;
   assign consume = out_valid && out_ready && !hold && !flush;

   always_comb begin
      state_nx       = state_q;
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         state_nx = OCC_EMPTY;
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  state_nx = OCC_ONE;
                  main_ld  = 1'b1;
               end
            end
            OCC_ONE: begin
               if (accept && consume) begin
                  main_ld = 1'b1;
               end else if (accept && SKID != 0) begin
                  state_nx = OCC_TWO;
                  skid_ld  = 1'b1;
               end else if (consume) begin
                  state_nx = OCC_EMPTY;
                  main_clr = 1'b1;
               end
            end
            OCC_TWO: begin
               // in_ready is low here, so only the skid entry can advance to the head.
               if (consume) begin
                  state_nx       = OCC_ONE;
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
               end
            end
            default: begin
               state_nx = OCC_EMPTY;
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= OCC_EMPTY;
      else        state_q <= state_nx;
   end

   assign main_d = main_from_skid ? skid_q : {ctrl_i, data_i};

   pipe_entry #(.W(W)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_ld),
      .clear (main_clr),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   if (SKID != 0) begin : g_skid
      pipe_entry #(.W(W)) u_skid (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (skid_ld),
         .clear (skid_clr),
         .d     ({ctrl_i, data_i}),
         .valid (skid_valid),
         .q     (skid_q)
      );
   end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
   end

   always_ff @(posedge clk) begin
      if (rst_n) assert (((state_q == OCC_TWO) == skid_valid) && ((state_q != OCC_EMPTY) == main_valid));
   end

   assign out_valid = main_valid;
   assign ctrl_o    = main_valid ? main_q[W-1:DATA_W] : '0;
   assign data_o    = (main_valid || CLEAR_DATA == 0) ? main_q[DATA_W-1:0] : '0;
   assign occ       = occ_count(state_q);

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (in_valid && !in_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference for the skid
// configuration plus directed checks of a pass-through, hold-data configuration.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int unsigned CW  = 16;
   localparam int unsigned DW  = 160;
   localparam int unsigned NW  = 16;
   localparam int unsigned OW  = 3 + CW + DW;
   localparam int unsigned BCW = 8;
   localparam int unsigned BDW = 16;
   localparam int unsigned BNW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, in_ready, out_valid, out_ready, flush, hold;
   logic [CW-1:0] ctrl_i, ctrl_o;
   logic [DW-1:0] data_i, data_o;
   logic [1:0]    occ;
   logic [NW-1:0] stall_cnt;

   logic           b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_hold;
   logic [BCW-1:0] b_ctrl_i, b_ctrl_o;
   logic [BDW-1:0] b_data_i, b_data_o;
   logic [1:0]     b_occ;
   logic [BNW-1:0] b_stall_cnt;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1), .CNT_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl_i(ctrl_i), .data_i(data_i), .out_valid(out_valid), .out_ready(out_ready),
      .ctrl_o(ctrl_o), .data_o(data_o), .flush(flush), .hold(hold),
      .occ(occ), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.CTRL_W(BCW), .DATA_W(BDW), .SKID(0), .CLEAR_DATA(0), .CNT_W(BNW)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .ctrl_i(b_ctrl_i), .data_i(b_data_i), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .ctrl_o(b_ctrl_o), .data_o(b_data_o), .flush(b_flush), .hold(b_hold),
      .occ(b_occ), .stall_cnt(b_stall_cnt)
   );

   typedef logic [CW+DW-1:0] ent_t;
   ent_t          sbq[$];
   logic [NW-1:0] m_cnt = '0;
   int            n_chk = 0;
   int            n_pass = 0;

   function automatic logic [OW-1:0] obs();
      return {out_valid, occ, ctrl_o, data_o};
   endfunction

   function automatic logic [OW-1:0] exp_out();
      if (sbq.size() == 0) return '0;
      return {1'b1, 2'(sbq.size()), sbq[0]};
   endfunction

   function automatic logic exp_rdy();
      return rst_n && (sbq.size() < 2) && !hold;
   endfunction

   // Advance one clock and update the reference queue and stall count.
   task automatic tick();
      logic rdy, acc, con;
      rdy = exp_rdy();
      acc = in_valid && rdy && !flush;
      con = (sbq.size() != 0) && out_ready && !hold && !flush;
      @(posedge clk);
      if (!rst_n) begin
         sbq.delete();
         m_cnt = '0;
      end else begin
         if (in_valid && !rdy && m_cnt != '1) m_cnt = m_cnt + 1'b1;
         if (flush) sbq.delete();
         else begin
            if (con) void'(sbq.pop_front());
            if (acc) sbq.push_back({ctrl_i, data_i});
         end
      end
      #1;
   endtask

   task automatic tickb();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
      ctrl_i = '0; data_i = '0;
      b_rst_n = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_hold = 1'b0;
      b_ctrl_i = '0; b_data_i = '0;
      #1;
      n_chk++; if ({in_ready, b_in_ready} !== 2'b00) $display("FAIL reset_rdy_low: got %b want 00", {in_ready, b_in_ready}); else n_pass++;
      tick(); tick();
      n_chk++; if (obs() !== '0) $display("FAIL reset_out: got %h want 0", obs()); else n_pass++;
      n_chk++; if (stall_cnt !== '0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else n_pass++;
      n_chk++; if ({b_out_valid, b_occ, b_ctrl_o, b_data_o} !== '0) $display("FAIL reset_b_out: got %h want 0", {b_out_valid, b_occ, b_ctrl_o, b_data_o}); else n_pass++;
      rst_n = 1'b1; b_rst_n = 1'b1;
      #1;
      n_chk++; if ({in_ready, b_in_ready} !== 2'b11) $display("FAIL reset_rdy_release: got %b want 11", {in_ready, b_in_ready}); else n_pass++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1; in_valid = 1'b1; ctrl_i = 16'h00A5;
      for (int i = 0; i < 2; i++) begin
         data_i = DW'(5 + i);
         #1;
         n_chk++; if (in_ready !== exp_rdy()) $display("FAIL stream_rdy: got %b want %b", in_ready, exp_rdy()); else n_pass++;
         tick();
         n_chk++; if ({out_valid, occ, ctrl_o, data_o} !== {1'b1, 2'd1, 16'h00A5, DW'(5 + i)})
            $display("FAIL stream_head: got %h want valid occ1 ctrl a5 data %0d", obs(), 5 + i); else n_pass++;
         n_chk++; if (obs() !== exp_out()) $display("FAIL stream_model: got %h want %h", obs(), exp_out()); else n_pass++;
      end
      in_valid = 1'b0;
      tick();
      n_chk++; if (obs() !== '0) $display("FAIL stream_drain: got %h want 0", obs()); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [NW-1:0] cnt0;
      cnt0 = m_cnt;
      out_ready = 1'b0; in_valid = 1'b1; ctrl_i = 16'h0042;
      data_i = DW'(1); tick();
      data_i = DW'(2); tick();
      n_chk++; if ({occ, in_ready} !== {2'd2, 1'b0}) $display("FAIL bp_full: got occ %0d rdy %b want occ 2 rdy 0", occ, in_ready); else n_pass++;
      n_chk++; if (stall_cnt !== cnt0) $display("FAIL bp_nostall: got %0d want %0d", stall_cnt, cnt0); else n_pass++;
      data_i = DW'(3);
      repeat (3) tick();
      n_chk++; if (stall_cnt !== NW'(cnt0 + 3)) $display("FAIL bp_stall: got %0d want %0d", stall_cnt, cnt0 + 3); else n_pass++;
      n_chk++; if (data_o !== DW'(1)) $display("FAIL bp_head1: got %0d want 1", data_o); else n_pass++;
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      n_chk++; if ({out_valid, occ, data_o} !== {1'b1, 2'd1, DW'(2)}) $display("FAIL bp_head2: got %h want occ1 data 2", obs()); else n_pass++;
      tick();
      n_chk++; if (obs() !== exp_out() || out_valid !== 1'b0) $display("FAIL bp_drain: got %h want %h", obs(), exp_out()); else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; ctrl_i = 16'h0077;
      data_i = DW'(7); tick();
      data_i = DW'(8); tick();
      flush = 1'b1; data_i = DW'(9); out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_chk++; if ({out_valid, occ, ctrl_o} !== '0) $display("FAIL flush_two: got %h want 0", {out_valid, occ, ctrl_o}); else n_pass++;
      tick();
      n_chk++; if (obs() !== '0) $display("FAIL flush_no9: got %h want 0", obs()); else n_pass++;
      out_ready = 1'b0; in_valid = 1'b1; data_i = DW'(4);
      tick();
      flush = 1'b1; data_i = DW'(9);
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL flush_offer_rdy: got %b want 1", in_ready); else n_pass++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_chk++; if (obs() !== '0 || obs() !== exp_out()) $display("FAIL flush_discard: got %h want 0", obs()); else n_pass++;
   endtask

   task automatic test_hold();
      out_ready = 1'b0; in_valid = 1'b1; ctrl_i = 16'h0101; data_i = DW'(10);
      tick();
      in_valid = 1'b0; out_ready = 1'b1; hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (in_ready !== 1'b0) $display("FAIL hold_rdy: got %b want 0", in_ready); else n_pass++;
         tick();
         n_chk++; if ({out_valid, occ, ctrl_o, data_o} !== {1'b1, 2'd1, 16'h0101, DW'(10)}) $display("FAIL hold_head: got %h want occ1 data 10", obs()); else n_pass++;
      end
      hold = 1'b0;
      tick();
      n_chk++; if (obs() !== '0) $display("FAIL hold_consume_once: got %h want 0", obs()); else n_pass++;
      out_ready = 1'b0; in_valid = 1'b1; data_i = DW'(11);
      tick();
      in_valid = 1'b0; hold = 1'b1; flush = 1'b1;
      tick();
      hold = 1'b0; flush = 1'b0;
      n_chk++; if (occ !== 2'd0 || out_valid !== 1'b0) $display("FAIL hold_flush: got occ %0d valid %b want 0 0", occ, out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      out_ready = 1'b0; in_valid = 1'b1; ctrl_i = 16'h0033;
      data_i = DW'(1); tick();
      data_i = DW'(2); tick();
      data_i = DW'(3);
      repeat (7) tick();
      n_chk++; if ({occ, stall_cnt} !== {2'd2, NW'(7)}) $display("FAIL rmid_pre: got occ %0d stall %0d want 2 7", occ, stall_cnt); else n_pass++;
      rst_n = 1'b0;
      tick();
      n_chk++; if ({out_valid, occ, stall_cnt, data_o} !== '0) $display("FAIL rmid_reset: got valid %b occ %0d stall %0d data %h", out_valid, occ, stall_cnt, data_o); else n_pass++;
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rmid_rdy: got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         hold      = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         ctrl_i    = CW'($urandom);
         data_i    = {$urandom, $urandom, $urandom, $urandom, $urandom};
         #1;
         n_chk++; if (in_ready !== exp_rdy()) $display("FAIL b2b_rdy: cycle %0d got %b want %b", i, in_ready, exp_rdy()); else n_pass++;
         tick();
         n_chk++; if (obs() !== exp_out()) $display("FAIL b2b_out: cycle %0d got %h want %h", i, obs(), exp_out()); else n_pass++;
         n_chk++; if (stall_cnt !== m_cnt) $display("FAIL b2b_stall: cycle %0d got %0d want %0d", i, stall_cnt, m_cnt); else n_pass++;
      end
      in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      n_chk++; if (obs() !== '0) $display("FAIL b2b_drain: got %h want 0", obs()); else n_pass++;
   endtask

   task automatic test_noskid();
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_ctrl_i = 8'h3C; b_data_i = 16'h0011;
      tickb();
      b_in_valid = 1'b0;
      #1;
      n_chk++; if ({b_out_valid, b_occ, b_ctrl_o, b_data_o, b_in_ready} !== {1'b1, 2'd1, 8'h3C, 16'h0011, 1'b0})
         $display("FAIL noskid_full: got %h want 1_1_3c_0011_0", {b_out_valid, b_occ, b_ctrl_o, b_data_o, b_in_ready}); else n_pass++;
      b_in_valid = 1'b1; b_out_ready = 1'b1; b_ctrl_i = 8'h3D; b_data_i = 16'h0022;
      #1;
      n_chk++; if (b_in_ready !== 1'b1) $display("FAIL noskid_comb_rdy: got %b want 1", b_in_ready); else n_pass++;
      tickb();
      n_chk++; if ({b_out_valid, b_occ, b_ctrl_o, b_data_o} !== {1'b1, 2'd1, 8'h3D, 16'h0022})
         $display("FAIL noskid_swap: got %h want 1_1_3d_0022", {b_out_valid, b_occ, b_ctrl_o, b_data_o}); else n_pass++;
      b_in_valid = 1'b0;
      tickb();
      n_chk++; if ({b_out_valid, b_occ, b_ctrl_o, b_data_o} !== {1'b0, 2'd0, 8'h00, 16'h0022})
         $display("FAIL noskid_hold_data: got %h want 0_0_00_0022", {b_out_valid, b_occ, b_ctrl_o, b_data_o}); else n_pass++;
      n_chk++; if (b_stall_cnt !== 4'd0) $display("FAIL noskid_stall: got %0d want 0", b_stall_cnt); else n_pass++;
   endtask

   task automatic test_saturate();
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_data_i = 16'h0033;
      tickb();
      repeat (14) tickb();
      n_chk++; if (b_stall_cnt !== 4'd14) $display("FAIL sat_count: got %0d want 14", b_stall_cnt); else n_pass++;
      repeat (6) tickb();
      n_chk++; if (b_stall_cnt !== 4'hF) $display("FAIL sat_hold: got %0d want 15", b_stall_cnt); else n_pass++;
      b_in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_noskid();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 16: width of the control field; this field is zeroed whenever the output is not valid.
REQ-002 Parameter DATA_W, default 160: width of the data field (operands, PC, immediates, register indices).
REQ-003 Parameter SKID, default 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
REQ-004 Parameter CLEAR_DATA, default 1: 1 zeroes data_o when the output is not valid; 0 holds the last data value.
REQ-005 Parameter CNT_W, default 16: width of the stall statistics counter.
REQ-006 clk  input  1  the single clock; every flop is rising-edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 in_valid  input  1  upstream stage presents an entry.
REQ-009 in_ready  output  1  the stage can accept an entry this cycle.
REQ-010 ctrl_i  input  CTRL_W  incoming control field.
REQ-011 data_i  input  DATA_W  incoming data field.
REQ-012 out_valid  output  1  the head entry is valid.
REQ-013 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-014 ctrl_o / data_o  output  CTRL_W / DATA_W  head entry fields.
REQ-015 flush  input  1  discard all entries; highest priority after reset.
REQ-016 hold  input  1  global freeze (divider or cache stall).
REQ-017 occ  output  2  number of stored entries, 0..2.
REQ-018 stall_cnt  output  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-019 An accept SHALL be in_valid && in_ready && !hold && !flush; a consume SHALL be out_valid && out_ready && !hold && !flush.
REQ-020 The stage SHALL track occupancy as state EMPTY, ONE or TWO; TWO is reachable only when SKID=1.
REQ-021 State transitions SHALL be: EMPTY+accept->ONE; ONE+accept-only->TWO (SKID=1); ONE+consume-only->EMPTY; ONE+accept+consume->ONE; TWO+consume->ONE; otherwise the state is held.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N is presented at out_valid after edge N if the stage was empty.
REQ-023 Entries SHALL leave in the order they entered; the skid entry moves to the head on the consume of the main entry.
REQ-024 When SKID=1, in_ready SHALL be the registered term (state!=TWO) && !hold, with no combinational path from out_ready.
REQ-025 When SKID=0, in_ready SHALL be (state==EMPTY || out_ready) && !hold.
REQ-026 The flush SHALL force state EMPTY at the next edge; a handshake offered in the flush cycle is discarded; flush overrides hold.
REQ-027 When hold=1, the stage SHALL change no state and no entry.
REQ-028 When hold=1, out_valid SHALL still reflect the head entry, but no consume occurs.
REQ-029 While out_valid=0, ctrl_o SHALL be all zeros, so that a bubble never writes a register or memory.
REQ-030 While out_valid=0, data_o SHALL be zero if CLEAR_DATA=1 and SHALL hold its last value otherwise.
REQ-031 The stall_cnt counter SHALL increment by 1 per stall cycle and SHALL saturate at all-ones.
REQ-032 The stall_cnt counter SHALL not be cleared by flush.
REQ-033 The occ output SHALL equal the encoded state: 0, 1 or 2.

Reset
REQ-034 While rst_n=0 at an edge, the state SHALL become EMPTY and stall_cnt SHALL become 0.
REQ-035 While rst_n=0 at an edge, the main and skid entries SHALL be zeroed, which gives out_valid=0, ctrl_o=0, data_o=0 and occ=0.
REQ-036 While rst_n=0 at an edge, in_ready SHALL be 0 during the reset cycle and SHALL be 1 from the first cycle after rst_n=1, unless hold=1.
REQ-037 Reset asserted mid-operation SHALL discard both entries with no partial transfer.

Structure
REQ-038 The occupancy state enum and the shared default widths SHALL live in the shared pipeline package.
REQ-039 The per-stage CTRL_W/DATA_W values (decode-execute, execute-memory, memory-writeback) SHALL live in the shared pipeline package.
REQ-040 The single storage sub-module SHALL be pipe_entry: one CTRL_W+DATA_W register with valid, load enable and clear.
REQ-041 The block SHALL instantiate pipe_entry once for the main entry, and once more for the skid entry when SKID=1.

Verification
REQ-042 Stream without backpressure: ctrl_i=0x00A5, data_i=5 then 6; out_ready=1; SKID=1 -> outputs 5 then 6, each one cycle after accept; occ=1 throughout.
REQ-043 Backpressure: out_ready=0; accept 1 then 2 -> occ=2, in_ready=0, stall_cnt increments from the third cycle; release out_ready -> outputs 1 then 2 in order.
REQ-044 Flush at occ=2 with in_valid=1 and data_i=9 -> next cycle occ=0, out_valid=0, ctrl_o=0; value 9 never appears.
REQ-045 hold=1 for 3 cycles at occ=1, out_ready=1 -> head unchanged, in_ready=0, no consume; after release the head is consumed once.
REQ-046 rst_n=0 for one cycle at occ=2 with stall_cnt=7 -> occ=0, stall_cnt=0, data_o=0; next cycle in_ready=1.
REQ-047 SKID=0, CLEAR_DATA=0: full stage, out_ready=1, in_valid=1 -> same-cycle accept and consume; after draining, data_o holds the last value and ctrl_o=0.
